// File: rtl/ap_ctrl_pkg.sv
// rtl/ap_ctrl_pkg.sv - shared widths and FSM state type for the ap_ctrl driver
package ap_ctrl_pkg;
  localparam int AP_TXN_W   = 16;
  localparam int AP_CYC_W   = 32;
  localparam int AP_MAX_OUT = 4;

  typedef enum logic [2:0] {IDLE, START, GAP, DRAIN, FIN} state_t;
endpackage

// File: rtl/ap_ctrl_if.sv
// rtl/ap_ctrl_if.sv - HLS block-level control handshake (ap_ctrl_chain)
interface ap_ctrl_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  modport master (output ap_start, output ap_continue, input ap_ready, input ap_done);
  modport slave  (input ap_start, input ap_continue, output ap_ready, output ap_done);
endinterface

// File: rtl/ap_ctrl_ts_fifo.sv
// rtl/ap_ctrl_ts_fifo.sv - start-timestamp FIFO, one entry per outstanding transaction
module ap_ctrl_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // Push and pop on an empty FIFO pass the incoming timestamp straight through.
  assign head    = empty ? push_data : mem[rd_ptr];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/ap_ctrl_driver.sv
// rtl/ap_ctrl_driver.sv - ap_ctrl_chain initiator with overlap limit and latency stats
module ap_ctrl_driver
  import ap_ctrl_pkg::*;
#(
  parameter int TXN_W   = AP_TXN_W,
  parameter int CYC_W   = AP_CYC_W,
  parameter int MAX_OUT = AP_MAX_OUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [TXN_W-1:0] cmd_count,
  input  logic [7:0]       cmd_gap,
  input  logic [7:0]       cmd_cont_delay,
  ap_ctrl_if.master        ap,
  output logic             busy,
  output logic             finish,
  output logic [TXN_W-1:0] done_count,
  output logic [CYC_W-1:0] last_latency,
  output logic [CYC_W-1:0] max_latency,
  output logic [CYC_W-1:0] total_cycles,
  output logic             err_spurious_done
);
  localparam int            OW      = $clog2(MAX_OUT) + 1;
  localparam logic [OW-1:0] MAX_LVL = OW'(MAX_OUT);

  state_t           state;
  logic [TXN_W-1:0] count_r, issued;
  logic [7:0]       gap_r, delay_r, gap_cnt, hold;
  logic [CYC_W-1:0] cyc, cyc_next, start_ts, head_ts, lat;
  logic [OW-1:0]    level, out_next;
  logic             accept, start_hs, done_acc, eff_nz, fifo_full, fifo_empty;

  assign accept         = cmd_valid && cmd_ready;
  assign start_hs       = ap.ap_start && ap.ap_ready;
  assign eff_nz         = !fifo_empty || start_hs;
  assign ap.ap_continue = ap.ap_done && (hold >= delay_r) && eff_nz;
  assign done_acc       = ap.ap_continue;
  assign out_next       = level + OW'(start_hs) - OW'(done_acc);
  assign cyc_next       = accept ? '0 : ((&cyc) ? cyc : cyc + CYC_W'(1));
  assign lat            = cyc - head_ts + CYC_W'(1);

  // FIFO occupancy doubles as the outstanding-transaction count.
  ap_ctrl_ts_fifo #(.DEPTH(MAX_OUT), .W(CYC_W)) u_ts_fifo (
    .clock, .reset, .push(start_hs), .pop(done_acc), .push_data(start_ts),
    .head(head_ts), .level, .full(fifo_full), .empty(fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE; cmd_ready <= 1'b0; ap.ap_start <= 1'b0;
      busy <= 1'b0; finish <= 1'b0; err_spurious_done <= 1'b0;
      count_r <= '0; issued <= '0; gap_r <= '0; delay_r <= '0;
      gap_cnt <= '0; hold <= '0; cyc <= '0; start_ts <= '0;
      done_count <= '0; last_latency <= '0; max_latency <= '0; total_cycles <= '0;
    end else begin
      cyc    <= cyc_next;
      finish <= 1'b0;
      if (ap.ap_done && !eff_nz) err_spurious_done <= 1'b1;
      if (!ap.ap_done || done_acc) hold <= '0;
      else if (hold != 8'hFF)      hold <= hold + 8'd1;
      if (done_acc) begin
        done_count   <= done_count + TXN_W'(1);
        last_latency <= lat;
        if (lat > max_latency) max_latency <= lat;
      end

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            count_r <= cmd_count; gap_r <= cmd_gap; delay_r <= cmd_cont_delay;
            issued <= '0; start_ts <= '0; cmd_ready <= 1'b0; busy <= 1'b1;
            done_count <= '0; last_latency <= '0; max_latency <= '0;
            total_cycles <= '0; err_spurious_done <= 1'b0;
            if (cmd_count == '0) begin
              state <= FIN; finish <= 1'b1;
            end else begin
              state <= START; ap.ap_start <= 1'b1;
            end
          end
        end
        START: begin
          if (start_hs) begin
            issued <= issued + TXN_W'(1);
            if (issued + TXN_W'(1) == count_r) begin
              state <= DRAIN; ap.ap_start <= 1'b0;
            end else if (gap_r == '0 && out_next < MAX_LVL) begin
              start_ts <= cyc_next;
            end else begin
              state <= GAP; ap.ap_start <= 1'b0; gap_cnt <= gap_r;
            end
          end
        end
        GAP: begin
          // gap_cnt parks at 1 (or 0) once the spacing has expired.
          if (gap_cnt > 8'd1) gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1 && out_next < MAX_LVL) begin
            state <= START; ap.ap_start <= 1'b1; start_ts <= cyc_next;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state <= FIN; finish <= 1'b1; total_cycles <= cyc;
          end
        end
        FIN: begin
          state <= IDLE; busy <= 1'b0; cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ap_ctrl_driver.sv
// tb/tb_ap_ctrl_driver.sv - directed self-checking bench for ap_ctrl_driver
`timescale 1ns/1ps
module tb_ap_ctrl_driver;
  import ap_ctrl_pkg::*;
  localparam int TXN_W = AP_TXN_W;
  localparam int CYC_W = AP_CYC_W;
  localparam int MAX_OUT = AP_MAX_OUT;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [TXN_W-1:0] cmd_count = '0;
  logic [7:0]       cmd_gap = '0;
  logic [7:0]       cmd_cont_delay = '0;
  logic             busy, finish, err_spurious_done;
  logic [TXN_W-1:0] done_count;
  logic [CYC_W-1:0] last_latency, max_latency, total_cycles;

  ap_ctrl_if ap ();

  ap_ctrl_driver #(.TXN_W(TXN_W), .CYC_W(CYC_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_gap(cmd_gap), .cmd_cont_delay(cmd_cont_delay),
    .ap(ap), .busy(busy), .finish(finish), .done_count(done_count),
    .last_latency(last_latency), .max_latency(max_latency),
    .total_cycles(total_cycles), .err_spurious_done(err_spurious_done)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // Kernel model / monitor controls (written by the main sequence only)
  int clr_seq = 0;
  int k_lat = 0;
  bit k_en = 1'b0;
  bit force_done = 1'b0;

  // Monitor state (written by the kernel process only)
  int cyc_i = 0, seen_clr = 0;
  int n_hs = 0, n_acc = 0, n_fin = 0, viol = 0, done_wait = 0;
  bit prev_start = 1'b0, prev_hs = 1'b0, cont_first = 1'b0;
  int due_q[$], rise_cyc[$], hs_cyc[$], acc_cyc[$];

  // Kernel: accepts starts immediately, raises done k_lat cycles after the start
  // handshake and holds it until continued. Inputs change only at negedge.
  initial begin
    ap.ap_ready = 1'b0;
    ap.ap_done  = 1'b0;
    forever begin
      @(negedge clock);
      cyc_i++;
      if (clr_seq != seen_clr) begin
        seen_clr = clr_seq;
        n_hs = 0; n_acc = 0; n_fin = 0; viol = 0; done_wait = 0;
        prev_start = 1'b0; prev_hs = 1'b0; cont_first = 1'b0;
        due_q.delete(); rise_cyc.delete(); hs_cyc.delete(); acc_cyc.delete();
      end
      ap.ap_ready = k_en && ap.ap_start;
      ap.ap_done  = force_done ||
                    (k_en && due_q.size() > 0 && cyc_i >= due_q[0]) ||
                    (k_en && ap.ap_ready && k_lat == 0 && due_q.size() == 0);
      #1;
      if (ap.ap_start && (n_hs - n_acc) >= MAX_OUT) viol++;
      if (ap.ap_start && (!prev_start || prev_hs)) begin
        rise_cyc.push_back(cyc_i);
        if (ap.ap_continue) cont_first = 1'b1;
      end
      if (ap.ap_done && !ap.ap_continue) done_wait++;
      prev_start = ap.ap_start;
      prev_hs    = ap.ap_start && ap.ap_ready;
      if (prev_hs) begin
        due_q.push_back(cyc_i + k_lat);
        hs_cyc.push_back(cyc_i);
        n_hs++;
      end
      if (ap.ap_done && ap.ap_continue) begin
        if (due_q.size() > 0) void'(due_q.pop_front());
        acc_cyc.push_back(cyc_i);
        n_acc++;
      end
      if (finish) n_fin++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int cnt, input int gap, input int dly);
    clr_seq++;
    @(negedge clock); #2;
    for (int i = 0; i < 50 && !cmd_ready; i++) begin @(negedge clock); #2; end
    cmd_count = TXN_W'(cnt); cmd_gap = 8'(gap); cmd_cont_delay = 8'(dly);
    cmd_valid = 1'b1;
    @(negedge clock); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_fin(input string tag, input int budget);
    for (int i = 0; i < budget && n_fin == 0; i++) begin @(negedge clock); #2; end
    chk(tag, n_fin, 1);
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_ctrl_outs", {ap.ap_start, ap.ap_continue, busy, finish, err_spurious_done}, 0);
    chk("rst_stats", {done_count, last_latency | max_latency | total_cycles}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #2;
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Back-to-back starts, done 10 cycles after each start
    k_en = 1'b1; k_lat = 10;
    start_run(3, 0, 0);
    wait_fin("t1_finish", 200);
    chk("t1_done_count", done_count, 3);
    chk("t1_last_latency", last_latency, 11);
    chk("t1_max_latency", max_latency, 11);
    chk("t1_total_cycles", total_cycles, 13);
    chk("t1_back_to_back", hs_cyc[2] - hs_cyc[0], 2);
    @(negedge clock); #2;
    chk("t1_busy_after", busy, 0);
    chk("t1_one_finish", n_fin, 1);

    // Start spacing of 5 idle cycles
    k_lat = 3;
    start_run(2, 5, 0);
    wait_fin("t2_finish", 200);
    chk("t2_gap_cycles", rise_cyc[1] - hs_cyc[0] - 1, 5);
    chk("t2_done_count", done_count, 2);
    chk("t2_last_latency", last_latency, 4);
    chk("t2_total_cycles", total_cycles, 10);

    // Overlap limit: done withheld for 50 cycles
    k_lat = 50;
    start_run(8, 0, 0);
    wait_fin("t3_finish", 400);
    chk("t3_done_count", done_count, 8);
    chk("t3_first4_b2b", hs_cyc[3] - hs_cyc[0], 3);
    chk("t3_resume_after_accept", rise_cyc[4], acc_cyc[0] + 1);
    chk("t3_start_at_max", viol, 0);
    chk("t3_max_latency", max_latency, 51);
    chk("t3_total_cycles", total_cycles, 105);

    // Continue delay of 3
    k_lat = 2;
    start_run(1, 0, 3);
    wait_fin("t4_finish", 100);
    chk("t4_continue_cycle", acc_cyc[0] - rise_cyc[0], 5);
    chk("t4_done_held_cycles", done_wait, 3);
    chk("t4_last_latency", last_latency, 6);
    chk("t4_total_cycles", total_cycles, 6);

    // Spurious done in IDLE, then a count=0 command
    k_en = 1'b0;
    force_done = 1'b1;
    repeat (2) @(negedge clock); #2;
    chk("t5_err_set", err_spurious_done, 1);
    chk("t5_no_continue", ap.ap_continue, 0);
    force_done = 1'b0;
    repeat (3) @(negedge clock); #2;
    chk("t5_err_sticky", err_spurious_done, 1);
    start_run(0, 0, 0);
    chk("t5_err_cleared", err_spurious_done, 0);
    chk("t5_finish_pulse", finish, 1);
    repeat (3) @(negedge clock); #2;
    chk("t5_one_finish", n_fin, 1);
    chk("t5_no_start", rise_cyc.size(), 0);
    chk("t5_idle_busy", busy, 0);

    // Reset mid-GAP with two outstanding
    k_en = 1'b1; k_lat = 100;
    start_run(4, 20, 0);
    for (int i = 0; i < 100 && n_hs < 2; i++) begin @(negedge clock); #2; end
    repeat (3) @(negedge clock); #2;
    chk("t6_two_issued", n_hs, 2);
    chk("t6_busy_before", busy, 1);
    reset = 1'b1;
    k_en = 1'b0;
    clr_seq++;
    #1;
    chk("t6_rst_ctrl_outs", {cmd_ready, ap.ap_start, ap.ap_continue, busy, finish, err_spurious_done}, 0);
    chk("t6_rst_stats", {done_count, last_latency | max_latency | total_cycles}, 0);
    repeat (2) @(negedge clock); #2;
    chk("t6_no_finish", n_fin, 0);
    reset = 1'b0;
    k_en = 1'b1; k_lat = 0;
    start_run(1, 0, 0);
    wait_fin("t6_finish", 100);
    chk("t6_done_count", done_count, 1);
    chk("t6_latency_one", last_latency, 1);
    chk("t6_cont_in_start_cycle", cont_first, 1);
    chk("t6_total_cycles", total_cycles, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ap_ctrl_driver.md
# ap_ctrl_driver

Synthesizable initiator for the HLS block-level control handshake (ap_start/ap_ready/ap_done/ap_continue, ap_ctrl_chain semantics). It issues a commanded number of kernel transactions with programmable start spacing and done back-pressure, and allows overlapped transactions up to a fixed limit. It measures per-transaction latency and total run time. It sits in the cosim/bring-up harness in front of the kernel top (e.g. spmv), in place of the testbench's hard-wired start logic, and pairs with the existing status monitors that observe the same signals.

## Interface
- TXN_W, 16, width of transaction counts
- CYC_W, 32, width of cycle counter and latency statistics
- MAX_OUT, 4, maximum transactions started but not done-accepted (≥1, power of two)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  run request
- cmd_ready  out  1  high only in IDLE
- cmd_count  in  TXN_W  transactions to issue
- cmd_gap  in  8  idle cycles between a ready handshake and the next ap_start
- cmd_cont_delay  in  8  cycles ap_done must be held before ap_continue is asserted
- ap_start  out  1  kernel start (registered)
- ap_ready  in  1  kernel accepted start
- ap_done  in  1  kernel result available (held until continued)
- ap_continue  out  1  done acknowledge (combinational, see Timing)
- busy  out  1  not IDLE
- finish  out  1  one-cycle pulse when the run completes
- done_count  out  TXN_W  dones accepted in the current/last run
- last_latency, max_latency  out  CYC_W each  latency statistics
- total_cycles  out  CYC_W  cycles from cmd accept to finish
- err_spurious_done  out  1  sticky; ap_done with nothing outstanding

## Operation
- States: IDLE, START, GAP, DRAIN, FIN.
- IDLE: cmd_ready=1. cmd_valid latches the cmd fields, clears the statistics and err flag, and zeroes the cycle counter. Next state is START, or FIN if cmd_count==0.
- START: ap_start=1 until an edge with ap_ready=1 (handshake). On the handshake:
  - issued++; push the start timestamp into the FIFO.
  - If issued==cmd_count: go to DRAIN.
  - Else if cmd_gap==0 and a slot is free: stay in START (back-to-back starts).
  - Else: go to GAP.
- GAP: ap_start=0. Counts cmd_gap cycles. Goes to START once the count has expired and outstanding<MAX_OUT; otherwise waits.
- DRAIN: ap_start=0. Goes to FIN when outstanding reaches 0.
- FIN: finish=1 for one cycle, then IDLE.
- Done path, independent of state: while ap_done=1, a hold counter runs. ap_continue = ap_done && hold ≥ cmd_cont_delay && eff_out>0.
  - eff_out = outstanding + (ap_start && ap_ready).
  - An edge with ap_done && ap_continue is a done-accept: pop the FIFO, done_count++, update the latency statistics, reset the hold counter.
- ap_done=1 with eff_out==0 sets err_spurious_done. ap_continue stays low in that case.
- outstanding: +1 on a start handshake, −1 on a done-accept. Both on the same edge leaves it unchanged.
- Latency = cycle counter at the done-accept cycle − timestamp + 1. The timestamp is the counter value in the first cycle ap_start was high for that transaction.
- max_latency: unsigned compare, updated on the same edge as last_latency.
- The cycle counter saturates at all-ones; it does not wrap.

## Timing
- Reset values: cmd_ready=0 while reset is asserted, and 1 from the first cycle after release. Every other output is 0. The FIFO and state are cleared. Reset during a run aborts it with no finish pulse.
- cmd accept at edge N → ap_start=1 in cycle N+1.
- Kernel with ready and done in its first start cycle, cont_delay=0 → ap_continue is high in that same cycle, and latency=1.
- total_cycles is captured at the FIN transition. It counts from the cycle after accept through the last done-accept cycle inclusive.
- cmd_ready is low during FIN; a new command is accepted no earlier than the IDLE cycle that follows.
- ap_start never rises while outstanding==MAX_OUT. A start handshake and a done-accept on the same edge at MAX_OUT keep ap_start high.

## Structure
- Package ap_ctrl_pkg: the state enum typedef and the width constants shared with the harness.
- Sub-module ap_ctrl_ts_fifo: a MAX_OUT-deep CYC_W timestamp FIFO with push/pop and full/empty flags. Simultaneous push and pop is legal, including when full or empty.
- The top level holds the FSM, the counters, and the statistics.

## Test plan
- count=3, gap=0, delay=0, kernel ready in the start cycle, done 10 cycles later → three back-to-back starts, done_count=3, last_latency=max_latency=11, one finish pulse, busy low afterwards.
- count=2, gap=5 → exactly 5 ap_start-low cycles between the first ready and the second ap_start.
- MAX_OUT=4, count=8, kernel withholds done for 50 cycles → ap_start held low after 4 handshakes, resumes on the cycle after the first done-accept, and all 8 complete.
- cont_delay=3, done asserted → ap_continue rises in the 4th ap_done cycle, latency includes those cycles, ap_done stays held until then.
- ap_done forced high in IDLE → err_spurious_done=1 and sticky, ap_continue=0. A new cmd clears the flag. count=0 → finish pulse with no ap_start.
- reset asserted mid-GAP with 2 outstanding → all outputs 0 immediately, no finish pulse. After release, a fresh count=1 run yields done_count=1.
